// File: rtl/ysyx_25060173_decode_stage.sv
// RV32 decode stage: combinational decode of the incoming word into a single
// registered, valid/ready handshaked bundle, plus a count of bundles taken by EXU.
module ysyx_25060173_decode_stage #(
    parameter int XLEN             = 32,
    parameter int RV32E            = 0,
    parameter int EN_M             = 0,
    parameter int HALT_ON_SELF_JAL = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic             out_wen,
    output logic [CNT_W-1:0] dec_count
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("ysyx_25060173_decode_stage supports XLEN=32 only");
        end
    endgenerate

    localparam logic [5:0] OP_ILLEGAL = 6'd0,  OP_ADD   = 6'd1,  OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SLL     = 6'd3,  OP_SLT   = 6'd4,  OP_SLTU  = 6'd5;
    localparam logic [5:0] OP_XOR     = 6'd6,  OP_SRL   = 6'd7,  OP_SRA   = 6'd8;
    localparam logic [5:0] OP_OR      = 6'd9,  OP_AND   = 6'd10, OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI    = 6'd12, OP_SLTIU = 6'd13, OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI     = 6'd15, OP_ANDI  = 6'd16, OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI    = 6'd18, OP_SRAI  = 6'd19, OP_LB    = 6'd20;
    localparam logic [5:0] OP_LH      = 6'd21, OP_LW    = 6'd22, OP_LBU   = 6'd23;
    localparam logic [5:0] OP_LHU     = 6'd24, OP_SB    = 6'd25, OP_SH    = 6'd26;
    localparam logic [5:0] OP_SW      = 6'd27, OP_BEQ   = 6'd28, OP_BNE   = 6'd29;
    localparam logic [5:0] OP_BLT     = 6'd30, OP_BGE   = 6'd31, OP_BLTU  = 6'd32;
    localparam logic [5:0] OP_BGEU    = 6'd33, OP_JAL   = 6'd34, OP_JALR  = 6'd35;
    localparam logic [5:0] OP_LUI     = 6'd36, OP_AUIPC = 6'd37, OP_EBREAK = 6'd38;
    localparam logic [5:0] OP_ECALL   = 6'd39;

    typedef enum logic [2:0] {FMT_N, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] w);
        return {{(XLEN-11){w[31]}}, w[30:20]};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] w);
        return {{(XLEN-11){w[31]}}, w[30:25], w[11:7]};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] w);
        return {{(XLEN-12){w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] w);
        return {{(XLEN-31){w[31]}}, w[30:12], 12'b0};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] w);
        return {{(XLEN-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    logic [6:0] opcode_p0, funct7_p0;
    logic [2:0] funct3_p0;
    logic [4:0] rd_raw_p0, rs1_raw_p0, rs2_raw_p0;

    assign opcode_p0  = in_inst[6:0];
    assign rd_raw_p0  = in_inst[11:7];
    assign funct3_p0  = in_inst[14:12];
    assign rs1_raw_p0 = in_inst[19:15];
    assign rs2_raw_p0 = in_inst[24:20];
    assign funct7_p0  = in_inst[31:25];

    // Stage p0: opcode/funct matching; every unmatched word stays OP_ILLEGAL
    logic [5:0] raw_op_p0;

    always_comb begin
        raw_op_p0 = OP_ILLEGAL;
        if (HALT_ON_SELF_JAL != 0 && in_inst == 32'h0000_006f) begin
            raw_op_p0 = OP_EBREAK;
        end else begin
            case (opcode_p0)
                7'b0110011: begin
                    if (funct7_p0 == 7'h00) begin
                        case (funct3_p0)
                            3'd0: raw_op_p0 = OP_ADD;
                            3'd1: raw_op_p0 = OP_SLL;
                            3'd2: raw_op_p0 = OP_SLT;
                            3'd3: raw_op_p0 = OP_SLTU;
                            3'd4: raw_op_p0 = OP_XOR;
                            3'd5: raw_op_p0 = OP_SRL;
                            3'd6: raw_op_p0 = OP_OR;
                            default: raw_op_p0 = OP_AND;
                        endcase
                    end else if (funct7_p0 == 7'h20) begin
                        if (funct3_p0 == 3'd0) raw_op_p0 = OP_SUB;
                        else if (funct3_p0 == 3'd5) raw_op_p0 = OP_SRA;
                    end else if (funct7_p0 == 7'h01 && EN_M != 0) begin
                        raw_op_p0 = {3'b101, funct3_p0};  // MUL..REMU occupy 40..47
                    end
                end
                7'b0010011: begin
                    case (funct3_p0)
                        3'd0: raw_op_p0 = OP_ADDI;
                        3'd2: raw_op_p0 = OP_SLTI;
                        3'd3: raw_op_p0 = OP_SLTIU;
                        3'd4: raw_op_p0 = OP_XORI;
                        3'd6: raw_op_p0 = OP_ORI;
                        3'd7: raw_op_p0 = OP_ANDI;
                        3'd1: if (funct7_p0 == 7'h00) raw_op_p0 = OP_SLLI;
                        default: begin
                            if (funct7_p0 == 7'h00) raw_op_p0 = OP_SRLI;
                            else if (funct7_p0 == 7'h20) raw_op_p0 = OP_SRAI;
                        end
                    endcase
                end
                7'b0000011: begin
                    case (funct3_p0)
                        3'd0: raw_op_p0 = OP_LB;
                        3'd1: raw_op_p0 = OP_LH;
                        3'd2: raw_op_p0 = OP_LW;
                        3'd4: raw_op_p0 = OP_LBU;
                        3'd5: raw_op_p0 = OP_LHU;
                        default: ;
                    endcase
                end
                7'b0100011: begin
                    case (funct3_p0)
                        3'd0: raw_op_p0 = OP_SB;
                        3'd1: raw_op_p0 = OP_SH;
                        3'd2: raw_op_p0 = OP_SW;
                        default: ;
                    endcase
                end
                7'b1100011: begin
                    case (funct3_p0)
                        3'd0: raw_op_p0 = OP_BEQ;
                        3'd1: raw_op_p0 = OP_BNE;
                        3'd4: raw_op_p0 = OP_BLT;
                        3'd5: raw_op_p0 = OP_BGE;
                        3'd6: raw_op_p0 = OP_BLTU;
                        3'd7: raw_op_p0 = OP_BGEU;
                        default: ;
                    endcase
                end
                7'b1101111: raw_op_p0 = OP_JAL;
                7'b1100111: if (funct3_p0 == 3'd0) raw_op_p0 = OP_JALR;
                7'b0110111: raw_op_p0 = OP_LUI;
                7'b0010111: raw_op_p0 = OP_AUIPC;
                7'b1110011: begin
                    if (in_inst == 32'h0010_0073) raw_op_p0 = OP_EBREAK;
                    else if (in_inst == 32'h0000_0073) raw_op_p0 = OP_ECALL;
                end
                default: ;
            endcase
        end
    end

    fmt_e fmt_p0;
    logic use_rd_p0, use_rs1_p0, use_rs2_p0, rv32e_bad_p0, illegal_p0, wen_p0;
    logic [5:0] op_p0;
    logic [4:0] rd_p0, rs1_p0, rs2_p0;
    logic signed [XLEN-1:0] imm_p0;

    always_comb begin
        fmt_p0 = FMT_N;
        if ((raw_op_p0 >= OP_ADD && raw_op_p0 <= OP_AND) || raw_op_p0 >= 6'd40) fmt_p0 = FMT_R;
        else if ((raw_op_p0 >= OP_ADDI && raw_op_p0 <= OP_LHU) || raw_op_p0 == OP_JALR) fmt_p0 = FMT_I;
        else if (raw_op_p0 >= OP_SB && raw_op_p0 <= OP_SW) fmt_p0 = FMT_S;
        else if (raw_op_p0 >= OP_BEQ && raw_op_p0 <= OP_BGEU) fmt_p0 = FMT_B;
        else if (raw_op_p0 == OP_LUI || raw_op_p0 == OP_AUIPC) fmt_p0 = FMT_U;
        else if (raw_op_p0 == OP_JAL) fmt_p0 = FMT_J;
    end

    assign use_rd_p0  = fmt_p0 inside {FMT_R, FMT_I, FMT_U, FMT_J};
    assign use_rs1_p0 = fmt_p0 inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign use_rs2_p0 = fmt_p0 inside {FMT_R, FMT_S, FMT_B};

    assign rv32e_bad_p0 = (RV32E != 0) && ((use_rd_p0 && rd_raw_p0[4]) ||
                                           (use_rs1_p0 && rs1_raw_p0[4]) ||
                                           (use_rs2_p0 && rs2_raw_p0[4]));
    assign illegal_p0 = (raw_op_p0 == OP_ILLEGAL) || rv32e_bad_p0;

    // Illegal words keep their raw register fields so the trap handler can inspect them
    always_comb begin
        op_p0  = illegal_p0 ? OP_ILLEGAL : raw_op_p0;
        rd_p0  = (illegal_p0 || use_rd_p0)  ? rd_raw_p0  : 5'd0;
        rs1_p0 = (illegal_p0 || use_rs1_p0) ? rs1_raw_p0 : 5'd0;
        rs2_p0 = (illegal_p0 || use_rs2_p0) ? rs2_raw_p0 : 5'd0;
        wen_p0 = !illegal_p0 && use_rd_p0 && (rd_raw_p0 != 5'd0);
        imm_p0 = '0;
        if (!illegal_p0) begin
            case (fmt_p0)
                FMT_I:   imm_p0 = imm_i(in_inst);
                FMT_S:   imm_p0 = imm_s(in_inst);
                FMT_B:   imm_p0 = imm_b(in_inst);
                FMT_U:   imm_p0 = imm_u(in_inst);
                FMT_J:   imm_p0 = imm_j(in_inst);
                default: imm_p0 = '0;
            endcase
        end
    end

    // Stage p1: single-entry output register and handshake
    logic                   vld_p1, illegal_p1, wen_p1;
    logic [5:0]             op_p1;
    logic [4:0]             rd_p1, rs1_p1, rs2_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   in_fire, out_fire;

    assign in_ready = !vld_p1 || out_ready;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = vld_p1 && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            op_p1      <= '0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            illegal_p1 <= 1'b0;
            wen_p1     <= 1'b0;
            cnt_p1     <= '0;
        end else begin
            if (out_fire) cnt_p1 <= cnt_p1 + CNT_W'(1);
            if (flush) vld_p1 <= 1'b0;
            else if (in_fire) vld_p1 <= 1'b1;
            else if (out_fire) vld_p1 <= 1'b0;
            if (in_fire) begin
                op_p1      <= op_p0;
                rd_p1      <= rd_p0;
                rs1_p1     <= rs1_p0;
                rs2_p1     <= rs2_p0;
                imm_p1     <= imm_p0;
                pc_p1      <= in_pc;
                illegal_p1 <= illegal_p0;
                wen_p1     <= wen_p0;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign out_op      = op_p1;
    assign out_rd      = rd_p1;
    assign out_rs1     = rs1_p1;
    assign out_rs2     = rs2_p1;
    assign out_imm     = imm_p1;
    assign out_pc      = pc_p1;
    assign out_illegal = illegal_p1;
    assign out_wen     = wen_p1;
    assign dec_count   = cnt_p1;

endmodule
